sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Parametrised SDRAM command arbiter: successor to the fixed write/read top-level FSM.
//  Sequences init -> arbitration, gives auto-refresh absolute priority, and shares the bus
//  round-robin among NUM_CH client engines (write/read/burst masters).
//  Muxes cmd/addr/BA/DQ-out onto the SDRAM pins; clients keep their own timing FSMs.
// PARAMETERS
//  NUM_CH    2   number of client channels (1..8)
//  ADDR_W    13  SDRAM address width
//  BA_W      2   bank address width
//  DQ_W      16  SDRAM data width
//  TMO_CYC   512 grant watchdog limit in clk cycles (used only with SDRAM_ARB_TMO_EN)
// PORTS
//  clk         in  1               system clock; SDRAM pins sampled on ~clk externally
//  rst_n       in  1               asynchronous, active-low reset
//  init_done   in  1               init engine finished (level, stays high)
//  init_cmd    in  4               {CS,RAS,CAS,WE} from init engine
//  init_addr   in  ADDR_W          address from init engine
//  aref_req    in  1               refresh engine requests the bus (level)
//  aref_cmd    in  4               refresh command
//  aref_addr   in  ADDR_W          refresh address
//  aref_end    in  1               1-cycle pulse: refresh sequence done
//  aref_en     out 1               refresh grant
//  ch_req      in  NUM_CH          per-channel request (level)
//  ch_end      in  NUM_CH          per-channel 1-cycle done pulse
//  ch_cmd      in  4*NUM_CH        packed commands, ch0 in [3:0]
//  ch_addr     in  ADDR_W*NUM_CH   packed addresses
//  ch_ba       in  BA_W*NUM_CH     packed bank addresses
//  ch_wdata    in  DQ_W*NUM_CH     packed write data
//  ch_dq_oe    in  NUM_CH          channel drives DQ this cycle
//  ch_gnt      out NUM_CH          one-hot channel grant
//  sd_cmd      out 4               {CS_N,RAS_N,CAS_N,WE_N}
//  sd_addr     out ADDR_W          SDRAM address
//  sd_ba       out BA_W            SDRAM bank
//  sd_dq_out   out DQ_W            DQ drive value (tristate buffer sits in pad wrapper)
//  sd_dq_oe    out 1               DQ output enable
//  tmo_err     out 1               1-cycle pulse on watchdog abort (tied 0 without macro)
// BEHAVIOUR
//  - One-hot FSM: INIT -> ARBIT (init_done) ; ARBIT -> AREF (aref_req) | GRANT (any ch_req) ;
//    AREF -> ARBIT (aref_end) ; GRANT -> ARBIT (ch_end of granted ch).
//  - Reset: state INIT, aref_en=0, ch_gnt=0, rr_ptr=0, tmo_err=0, sd_dq_oe=0.
//  - ARBIT decision is combinational on state_c; aref_en/ch_gnt register it -> 1-cycle latency
//    from request sampled in ARBIT to grant high. Only one grant is ever high at a time.
//  - Priority: aref_req beats all channels when both are seen in the same ARBIT cycle.
//    A running grant is never pre-empted; clients watch aref_req and finish early themselves.
//  - Round-robin: search starts at rr_ptr, wraps NUM_CH-1 -> 0; on ch_end, rr_ptr <= winner+1 (mod NUM_CH).
//  - Grants clear in the cycle after the end pulse; ch_end/aref_end from non-granted sources are ignored.
//  - Pin mux keyed on state_c: INIT -> init_*; ARBIT -> NOP(4'b0111), addr=0;
//    AREF -> aref_*; GRANT -> slice of granted channel. BA is 0 outside GRANT.
//  - sd_dq_oe = GRANT & ch_dq_oe[winner]; sd_dq_out = winner's ch_wdata slice, else 0.
//  - Requests dropped before grant are simply lost (no latching); requests in INIT are held off.
//  - Reset mid-operation: immediate return to INIT, all grants low, pins drive init_* values.
// CONFIGURATION
//  SDRAM_ARB_TMO_EN defined: an 8..16-bit counter runs while in GRANT;
//    reaching TMO_CYC without ch_end forces ARBIT, drops ch_gnt, pulses tmo_err,
//    advances rr_ptr past the offender.
//  SDRAM_ARB_TMO_EN undefined: no counter; a grant is held until ch_end; tmo_err tied 0.
// STRUCTURE
//  Shared package sdram_pkg: CMD_NOP/CMD_PRE/CMD_AREF/CMD_ACT/CMD_WR/CMD_RD/CMD_MRS
//    codes and FSM state encodings (one-hot, 4 bits).
//  One sub-module: sdram_rr_pick (req vector + ptr -> one-hot winner + index), combinational.
// TESTING
//  1 init_done rises at cycle 10 -> state ARBIT at cycle 11, sd_cmd=4'b0111 while idle.
//  2 aref_req & ch_req=2'b11 in the same ARBIT cycle -> aref_en=1 next cycle, ch_gnt=0
//    until aref_end; then ch0 wins.
//  3 NUM_CH=4, all ch_req held high, each ch_end 5 cycles after grant -> grants 0,1,2,3,0 in order.
//  4 ch1 granted with ch_dq_oe=1, ch_wdata[31:16]=16'hA5A5 -> sd_dq_oe=1, sd_dq_out=16'hA5A5,
//    ch0 data never visible.
//  5 rst_n low during GRANT -> next edge ch_gnt=0, state INIT, sd_cmd=init_cmd.
//  6 SDRAM_ARB_TMO_EN, TMO_CYC=16, ch0 never ends -> tmo_err pulse at grant+16, ch1 granted next.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: pin command codes {CS_N,RAS_N,CAS_N,WE_N}
// and the one-hot arbiter state encoding.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [3:0] {
        ST_INIT  = 4'b0001,
        ST_ARBIT = 4'b0010,
        ST_AREF  = 4'b0100,
        ST_GRANT = 4'b1000
    } state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter and its engines/pins.
// master: init/refresh/client engines plus pin consumer; slave: the arbiter.
interface sdram_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
);
    // init engine
    logic                     init_done;
    logic [3:0]               init_cmd;
    logic [ADDR_W-1:0]        init_addr;
    // refresh engine
    logic                     aref_req;
    logic [3:0]               aref_cmd;
    logic [ADDR_W-1:0]        aref_addr;
    logic                     aref_end;
    logic                     aref_en;
    // client channels, ch0 in the lowest slice
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_end;
    logic [4*NUM_CH-1:0]      ch_cmd;
    logic [ADDR_W*NUM_CH-1:0] ch_addr;
    logic [BA_W*NUM_CH-1:0]   ch_ba;
    logic [DQ_W*NUM_CH-1:0]   ch_wdata;
    logic [NUM_CH-1:0]        ch_dq_oe;
    logic [NUM_CH-1:0]        ch_gnt;
    // SDRAM pins
    logic [3:0]               sd_cmd;
    logic [ADDR_W-1:0]        sd_addr;
    logic [BA_W-1:0]          sd_ba;
    logic [DQ_W-1:0]          sd_dq_out;
    logic                     sd_dq_oe;
    logic                     tmo_err;

    modport master (
        output init_done, init_cmd, init_addr,
        output aref_req, aref_cmd, aref_addr, aref_end,
        output ch_req, ch_end, ch_cmd, ch_addr, ch_ba, ch_wdata, ch_dq_oe,
        input  aref_en, ch_gnt,
        input  sd_cmd, sd_addr, sd_ba, sd_dq_out, sd_dq_oe, tmo_err
    );

    modport slave (
        input  init_done, init_cmd, init_addr,
        input  aref_req, aref_cmd, aref_addr, aref_end,
        input  ch_req, ch_end, ch_cmd, ch_addr, ch_ba, ch_wdata, ch_dq_oe,
        output aref_en, ch_gnt,
        output sd_cmd, sd_addr, sd_ba, sd_dq_out, sd_dq_oe, tmo_err
    );

endinterface

// File: rtl/sdram_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping to 0.
// Purely combinational; returns a one-hot grant, its index and a valid flag.
module sdram_rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    int j;

    // Scan channels starting from ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: init -> arbitration, refresh has absolute priority,
// client channels share the pins round-robin. Clients own their timing FSMs;
// this block only grants the bus and muxes cmd/addr/BA/DQ onto the pins.
// Optional grant watchdog: define SDRAM_ARB_TMO_EN.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 13,
    parameter int BA_W    = 2,
    parameter int DQ_W    = 16,
    parameter int TMO_CYC = 512
) (
    input logic             clk,
    input logic             rst_n,
    sdram_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 8 || TMO_CYC < 2) begin : g_bad_param
        $error("sdram_arbiter: NUM_CH must be 1..8 and TMO_CYC >= 2");
    end

    state_t            state_c;
    logic              aref_en_q;
    logic [NUM_CH-1:0] ch_gnt_q;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx_q;
    logic [IDX_W-1:0]  next_ptr;
    logic              ch_end_win;

    logic [NUM_CH-1:0] pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

`ifdef SDRAM_ARB_TMO_EN
    localparam int TMO_W_RAW = $clog2(TMO_CYC);
    localparam int TMO_W = (TMO_W_RAW < 8) ? 8 : ((TMO_W_RAW > 16) ? 16 : TMO_W_RAW);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_err_q;
`endif

    sdram_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req (bus.ch_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Only the granted channel's end pulse counts; the pointer moves past the winner.
    assign ch_end_win = bus.ch_end[win_idx_q];
    assign next_ptr   = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + IDX_W'(1);

    // Arbiter FSM with registered grants: decision in ARBIT, grant visible next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_c   <= ST_INIT;
            aref_en_q <= 1'b0;
            ch_gnt_q  <= '0;
            rr_ptr    <= '0;
            win_idx_q <= '0;
`ifdef SDRAM_ARB_TMO_EN
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
`ifdef SDRAM_ARB_TMO_EN
            tmo_err_q <= 1'b0;
`endif
            // NOTE: non-blocking assignments so every register sees pre-edge values, like real flops.
            case (state_c)
                ST_INIT: begin
                    if (bus.init_done) state_c <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (bus.aref_req) begin
                        state_c   <= ST_AREF;
                        aref_en_q <= 1'b1;
                    end else if (pick_any) begin
                        state_c   <= ST_GRANT;
                        ch_gnt_q  <= pick_gnt;
                        win_idx_q <= pick_idx;
`ifdef SDRAM_ARB_TMO_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                ST_AREF: begin
                    if (bus.aref_end) begin
                        state_c   <= ST_ARBIT;
                        aref_en_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (ch_end_win) begin
                        state_c  <= ST_ARBIT;
                        ch_gnt_q <= '0;
                        rr_ptr   <= next_ptr;
                    end
`ifdef SDRAM_ARB_TMO_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state_c   <= ST_ARBIT;
                        ch_gnt_q  <= '0;
                        rr_ptr    <= next_ptr;
                        tmo_err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: begin
                    state_c   <= ST_INIT;
                    aref_en_q <= 1'b0;
                    ch_gnt_q  <= '0;
                end
            endcase
        end
    end

    assign bus.aref_en = aref_en_q;
    assign bus.ch_gnt  = ch_gnt_q;
`ifdef SDRAM_ARB_TMO_EN
    assign bus.tmo_err = tmo_err_q;
`else
    assign bus.tmo_err = 1'b0;
`endif

    // Pin mux keyed on the current state; the granted channel's slices drive the pins.
    always_comb begin
        bus.sd_cmd    = CMD_NOP;
        bus.sd_addr   = '0;
        bus.sd_ba     = '0;
        bus.sd_dq_out = '0;
        bus.sd_dq_oe  = 1'b0;
        case (state_c)
            ST_INIT: begin
                bus.sd_cmd  = bus.init_cmd;
                bus.sd_addr = bus.init_addr;
            end
            ST_AREF: begin
                bus.sd_cmd  = bus.aref_cmd;
                bus.sd_addr = bus.aref_addr;
            end
            ST_GRANT: begin
                bus.sd_cmd    = bus.ch_cmd[int'(win_idx_q)*4 +: 4];
                bus.sd_addr   = bus.ch_addr[int'(win_idx_q)*ADDR_W +: ADDR_W];
                bus.sd_ba     = bus.ch_ba[int'(win_idx_q)*BA_W +: BA_W];
                bus.sd_dq_out = bus.ch_wdata[int'(win_idx_q)*DQ_W +: DQ_W];
                bus.sd_dq_oe  = bus.ch_dq_oe[win_idx_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter (NUM_CH=4, TMO_CYC=16).
// Table of per-cycle vectors plus hand sequences for round-robin,
// reset during a grant and (with SDRAM_ARB_TMO_EN) the watchdog.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;

    localparam logic [12:0] INIT_ADDR = 13'h0155;
    localparam logic [12:0] AREF_ADDR = 13'h0400;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    sdram_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

    sdram_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W),
        .DQ_W   (DQ_W),
        .TMO_CYC(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    typedef struct {
        logic        aref_req;
        logic        aref_end;
        logic [3:0]  ch_req;
        logic [3:0]  ch_end;
        logic [3:0]  ch_dq_oe;
        logic        x_aref_en;
        logic [3:0]  x_gnt;
        logic [3:0]  x_cmd;
        logic [12:0] x_addr;
        logic [1:0]  x_ba;
        logic        x_oe;
        logic [15:0] x_dout;
    } vec_t;

    function automatic vec_t mkv(logic ar, logic ae, logic [3:0] rq, logic [3:0] en,
                                 logic [3:0] oe, logic x_ar, logic [3:0] x_g,
                                 logic [3:0] x_c, logic [12:0] x_a, logic [1:0] x_b,
                                 logic x_oe, logic [15:0] x_d);
        vec_t v;
        v.aref_req = ar;   v.aref_end = ae;  v.ch_req = rq;  v.ch_end = en;
        v.ch_dq_oe = oe;   v.x_aref_en = x_ar; v.x_gnt = x_g; v.x_cmd = x_c;
        v.x_addr   = x_a;  v.x_ba = x_b;     v.x_oe = x_oe;  v.x_dout = x_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.init_done = 1'b0;
        bus.aref_req  = 1'b0;
        bus.aref_end  = 1'b0;
        bus.ch_req    = '0;
        bus.ch_end    = '0;
        bus.ch_dq_oe  = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    vec_t vecs[14];
    int   rr_exp[5] = '{0, 1, 2, 3, 0};
    logic got;

    initial begin
        n_pass  = 0;
        n_total = 0;

        // static data: ch0 WR, ch1 RD, ch2 ACT, ch3 PRE; addr 0x100*(i+1); ba=i
        bus.init_cmd  = CMD_MRS;
        bus.init_addr = INIT_ADDR;
        bus.aref_cmd  = CMD_AREF;
        bus.aref_addr = AREF_ADDR;
        bus.ch_cmd    = {CMD_PRE, CMD_ACT, CMD_RD, CMD_WR};
        bus.ch_addr   = {13'h0400, 13'h0300, 13'h0200, 13'h0100};
        bus.ch_ba     = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.ch_wdata  = {16'h3333, 16'h2222, 16'hA5A5, 16'h1111};

        //              ar ae rq    en    oe    x_ar gnt   cmd       addr       ba oe dout
        vecs[0]  = mkv(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);
        vecs[1]  = mkv(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);
        vecs[2]  = mkv(1, 0, 4'h3, 4'h0, 4'h0, 1, 4'h0, CMD_AREF, AREF_ADDR, 0, 0, 16'h0);
        vecs[3]  = mkv(1, 0, 4'h3, 4'h0, 4'h0, 1, 4'h0, CMD_AREF, AREF_ADDR, 0, 0, 16'h0);
        vecs[4]  = mkv(1, 0, 4'h3, 4'h1, 4'h0, 1, 4'h0, CMD_AREF, AREF_ADDR, 0, 0, 16'h0);
        vecs[5]  = mkv(0, 1, 4'h3, 4'h0, 4'h0, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);
        vecs[6]  = mkv(0, 0, 4'h3, 4'h0, 4'h2, 0, 4'h1, CMD_WR,   13'h0100,  0, 0, 16'h1111);
        vecs[7]  = mkv(0, 0, 4'h3, 4'h2, 4'h2, 0, 4'h1, CMD_WR,   13'h0100,  0, 0, 16'h1111);
        vecs[8]  = mkv(0, 0, 4'h3, 4'h1, 4'h2, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);
        vecs[9]  = mkv(0, 0, 4'h3, 4'h0, 4'h2, 0, 4'h2, CMD_RD,   13'h0200,  1, 1, 16'hA5A5);
        vecs[10] = mkv(0, 0, 4'h3, 4'h2, 4'h2, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);
        vecs[11] = mkv(0, 0, 4'h3, 4'h0, 4'h2, 0, 4'h1, CMD_WR,   13'h0100,  0, 0, 16'h1111);
        vecs[12] = mkv(0, 0, 4'h0, 4'h1, 4'h2, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);
        vecs[13] = mkv(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, CMD_NOP,  13'h0,     0, 0, 16'h0);

        // reset state
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_aref_en", 32'(bus.aref_en), 0);
        check("rst_ch_gnt",  32'(bus.ch_gnt), 0);
        check("rst_tmo_err", 32'(bus.tmo_err), 0);
        check("rst_dq_oe",   32'(bus.sd_dq_oe), 0);
        check("rst_sd_cmd",  32'(bus.sd_cmd), 32'(CMD_MRS));
        step();
        rst_n = 1'b1;

        // INIT holds off all requests for 10 cycles
        bus.ch_req   = 4'hF;
        bus.aref_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("init_gnt",    32'(bus.ch_gnt), 0);
            check("init_aref",   32'(bus.aref_en), 0);
            check("init_cmd",    32'(bus.sd_cmd), 32'(CMD_MRS));
            check("init_addr",   32'(bus.sd_addr), 32'(INIT_ADDR));
        end

        // table: init_done rises, refresh priority, round-robin, data mux
        bus.init_done = 1'b1;
        for (int k = 0; k < 14; k++) begin
            bus.aref_req = vecs[k].aref_req;
            bus.aref_end = vecs[k].aref_end;
            bus.ch_req   = vecs[k].ch_req;
            bus.ch_end   = vecs[k].ch_end;
            bus.ch_dq_oe = vecs[k].ch_dq_oe;
            step();
            check($sformatf("v%0d_aref_en", k), 32'(bus.aref_en),   32'(vecs[k].x_aref_en));
            check($sformatf("v%0d_ch_gnt", k),  32'(bus.ch_gnt),    32'(vecs[k].x_gnt));
            check($sformatf("v%0d_sd_cmd", k),  32'(bus.sd_cmd),    32'(vecs[k].x_cmd));
            check($sformatf("v%0d_sd_addr", k), 32'(bus.sd_addr),   32'(vecs[k].x_addr));
            check($sformatf("v%0d_sd_ba", k),   32'(bus.sd_ba),     32'(vecs[k].x_ba));
            check($sformatf("v%0d_dq_oe", k),   32'(bus.sd_dq_oe),  32'(vecs[k].x_oe));
            check($sformatf("v%0d_dq_out", k),  32'(bus.sd_dq_out), 32'(vecs[k].x_dout));
        end
        bus.aref_end = 1'b0;
        bus.ch_end   = '0;

        // round-robin with all channels requesting: 0,1,2,3,0
        do_reset();
        bus.init_done = 1'b1;
        step();
        bus.ch_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                step();
                if (bus.ch_gnt != '0) got = 1'b1;
            end
            check($sformatf("rr%0d_seen", k), 32'(got), 1);
            check($sformatf("rr%0d_gnt", k),  32'(bus.ch_gnt), 32'(1) << rr_exp[k]);
            repeat (4) step();
            check($sformatf("rr%0d_hold", k), 32'(bus.ch_gnt), 32'(1) << rr_exp[k]);
            bus.ch_end = 4'(1 << rr_exp[k]);
            step();
            bus.ch_end = '0;
            check($sformatf("rr%0d_clear", k), 32'(bus.ch_gnt), 0);
        end

        // reset asserted during a grant
        step();
        check("mid_gnt_before", 32'(bus.ch_gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_gnt_async", 32'(bus.ch_gnt), 0);
        step();
        check("mid_gnt",  32'(bus.ch_gnt), 0);
        check("mid_cmd",  32'(bus.sd_cmd), 32'(CMD_MRS));
        check("mid_addr", 32'(bus.sd_addr), 32'(INIT_ADDR));
        check("mid_oe",   32'(bus.sd_dq_oe), 0);
        rst_n = 1'b1;

`ifdef SDRAM_ARB_TMO_EN
        // watchdog: ch0 never ends, aborted at grant+16, ch1 next
        do_reset();
        bus.init_done = 1'b1;
        step();
        bus.ch_req = 4'h3;
        step();
        check("tmo_gnt0", 32'(bus.ch_gnt), 32'h1);
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 15) begin
                check("tmo_k15_err", 32'(bus.tmo_err), 0);
                check("tmo_k15_gnt", 32'(bus.ch_gnt), 32'h1);
            end
            if (k == 16) begin
                check("tmo_k16_err", 32'(bus.tmo_err), 1);
                check("tmo_k16_gnt", 32'(bus.ch_gnt), 0);
            end
            if (k == 17) begin
                check("tmo_k17_err", 32'(bus.tmo_err), 0);
                check("tmo_k17_gnt", 32'(bus.ch_gnt), 32'h2);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
